// File: rtl/a78_sd_loader.sv
// a78_sd_loader: streams an .A78 image from sd_controller into ROM RAM.
// The header gives the payload size; the payload is written so that it ends at the top of ROM.
module a78_sd_loader #(
  parameter int ROM_SIZE       = 49152,
  parameter int HEADER_BYTES   = 128,
  parameter int SECTOR_BYTES   = 512,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_sector,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  input  logic        sd_ready,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic [17:0] rom_size,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, RECV = 3'd2, NEXT = 3'd3, DONE = 3'd4, ERR = 3'd5;
  localparam logic [71:0] MAGIC = "ATARI7800";
  localparam int CW = $clog2(SECTOR_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(HEADER_BYTES + 1);
  logic [2:0]    state;
  logic [31:0]   sector, size;
  logic [SW-1:0] s;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic [17:0]   p;
  logic [15:0]   base;
  logic [71:0]   magic_sh;
  logic          bad_magic, prev, rise, hdr, tmo;
  assign rise       = sd_byte_available & ~prev;
  assign hdr        = s == SW'(HEADER_BYTES);
  assign tmo        = timer == TW'(TIMEOUT_CYCLES - 1);
  assign magic_sh   = MAGIC << {s[3:0] - 4'd1, 3'b000};
  assign sd_rd      = state == REQ;
  assign sd_address = sector;
  assign busy       = state == REQ || state == RECV || state == NEXT;
  assign done       = state == DONE;
  assign error      = state == ERR;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sector    <= '0;
      size      <= '0;
      s         <= '0;
      cnt       <= '0;
      timer     <= '0;
      p         <= '0;
      base      <= '0;
      bad_magic <= 1'b0;
      prev      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      rom_size  <= '0;
    end else begin
      mem_we <= 1'b0;
      prev   <= sd_byte_available;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          sector    <= start_sector;
          size      <= '0;
          s         <= '0;
          cnt       <= '0;
          timer     <= '0;
          p         <= '0;
          bad_magic <= 1'b0;
          rom_size  <= '0;
          state     <= REQ;
        end
        REQ: if (!sd_ready) begin
          cnt   <= '0;
          timer <= '0;
          state <= RECV;
        end else if (tmo) state <= ERR;
        else timer <= timer + 1'b1;
        RECV: if (rise) begin
          timer <= '0;
          cnt   <= cnt + 1'b1;
          if (!hdr) s <= s + 1'b1;
          if (s >= SW'(1) && s <= SW'(9) && sd_dout != magic_sh[71:64]) bad_magic <= 1'b1;
          if (s >= SW'(49) && s <= SW'(52)) size <= {size[23:0], sd_dout};
          // header fully parsed: validate before any payload byte can be written
          if (s == SW'(HEADER_BYTES - 1)) begin
            if (bad_magic || size == '0 || size > 32'(ROM_SIZE)) state <= ERR;
            else begin
              rom_size <= size[17:0];
              base     <= 16'(32'(ROM_SIZE) - size);
            end
          end
          if (hdr && p < rom_size) begin
            mem_we   <= 1'b1;
            mem_addr <= base + p[15:0];
            mem_data <= sd_dout;
            p        <= p + 1'b1;
          end
        end else if (sd_ready) state <= cnt == CW'(SECTOR_BYTES) ? NEXT : ERR;
        else if (tmo) state <= ERR;
        else timer <= timer + 1'b1;
        NEXT: if (hdr && p == rom_size) state <= DONE;
        else begin
          sector <= sector + 1'b1;
          timer  <= '0;
          state  <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/a78_sd_loader.md
Name: a78_sd_loader

Overview:
- Streams an .A78 cartridge image from the SD card into the cartridge ROM RAM.
- Sits downstream of sd_controller: drives its rd/address handshake and consumes its dout/byte_available stream.
- Sits upstream of the rom_memory write port in top.
- Parses the 128-byte A78 header for magic and ROM size, then writes the payload so the image ends at the top of ROM space ($FFFF).

Parameters:
- ROM_SIZE, 49152, bytes of ROM RAM; ROM-relative index 0 maps to CPU $4000.
- HEADER_BYTES, 128, A78 header length skipped before payload.
- SECTOR_BYTES, 512, bytes delivered per sd_controller read.
- TIMEOUT_CYCLES, 1048576, max cycles waiting for any single sd_controller transition.

Ports:
- clk  in  1  system clock, 27MHz.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load, ignored while busy.
- start_sector  in  32  SDHC sector holding header byte 0; sampled on start.
- sd_rd  out  1  read request to sd_controller.
- sd_address  out  32  sector number to sd_controller.
- sd_ready  in  1  sd_controller idle/ready.
- sd_dout  in  8  sd_controller read byte.
- sd_byte_available  in  1  byte-valid level from sd_controller.
- mem_we  out  1  one-cycle ROM RAM write strobe.
- mem_addr  out  16  ROM-relative write index (0..ROM_SIZE-1).
- mem_data  out  8  ROM RAM write data.
- rom_size  out  18  payload size from the header, valid when done=1.
- busy  out  1  load in progress.
- done  out  1  load completed OK; held until next accepted start.
- error  out  1  load failed; held until next accepted start.

Behaviour:
- Reset (async, clk-independent): state=IDLE. sd_rd, mem_we, busy, done and error are 0. sd_address, mem_addr, mem_data and rom_size are 0. All internal counters are cleared.
- Reset mid-load aborts immediately; no further mem_we. The next start after reset release runs normally.
- States: IDLE, REQ, RECV, NEXT, DONE, ERR.
- IDLE:
  - start=1 latches sector=start_sector, clears stream index, byte counter, done and error, sets busy=1, goes to REQ.
  - start in any other state is ignored.
- REQ:
  - sd_rd=1, sd_address=sector.
  - sd_rd is held until sd_ready samples 0. Then sd_rd=0 the next cycle and the state goes to RECV.
  - If sd_ready stays 1 for TIMEOUT_CYCLES: ERR.
- RECV, byte capture:
  - A byte is taken on the rising edge of sd_byte_available: current=1 and registered previous=0.
  - sd_dout is sampled in that edge cycle; one byte per edge regardless of high-level duration.
- RECV, stream index s (counted across sectors, 0-based):
  - s=1..9 are compared to "ATARI7800"; any mismatch sets a sticky bad_magic flag.
  - s=49..52 form a big-endian 32-bit size.
  - At s=127: if bad_magic, size==0 or size>ROM_SIZE, go to ERR with no mem_we ever issued. Otherwise rom_size=size[17:0] and base=ROM_SIZE-size.
- RECV, payload writes:
  - For s>=128 and payload count p<rom_size: mem_we pulses the cycle after the edge cycle, with mem_addr=base+p and mem_data=captured byte. p then increments.
  - Bytes with p>=rom_size, i.e. sector tail padding, are consumed without writes.
- RECV, sector end:
  - Exactly SECTOR_BYTES edges are counted per sector.
  - When sd_ready returns to 1: if the count is not 512, go to ERR (short sector). Otherwise go to NEXT.
  - No edge and no sd_ready rise for TIMEOUT_CYCLES: ERR.
  - The timeout counter resets on each edge.
- NEXT:
  - If p==rom_size: go to DONE.
  - Otherwise sector=sector+1 (32-bit wrap allowed) and go to REQ.
  - Header-only sectors always continue.
- DONE: busy=0, done=1; waits for start.
- ERR: busy=0, error=1, sd_rd=0; waits for start.
- Width rules:
  - mem_addr is 16 bits, because base+p < ROM_SIZE always.
  - The size compare uses the full 32 bits before truncation.

Test Plan:
- Valid header, size=0x00008000, start_sector=2050 -> 32768 writes at mem_addr 0x4000..0xBFFF in order. Sectors 2050..2114 are requested (65 reads). done=1, rom_size=0x08000, no error.
- Header with "ATARI7801" at s=1..9 -> error=1 right after s=127, zero mem_we, sd_rd never reasserted.
- Size=0x00010000 (>49152) -> error=1, no writes. Size=0x0000C000 -> writes mem_addr 0x0000..0xBFFF, done=1.
- sd_ready held 1 after sd_rd asserted -> error=1 exactly TIMEOUT_CYCLES later, sd_rd deasserted.
- sd_byte_available held high 5 cycles per byte, plus a start pulse issued mid-load -> one write per byte, start ignored, identical memory image.
- Reset asserted during the 3rd sector -> outputs at reset values within the same cycle. A new start then loads correctly from start_sector.
